or_gate_tester: RTL and testbench
=================================

OR_GATE_TESTER -- requirements
Module: or_gate_tester

Interface
REQ-001 SHALL have parameter SETTLE_CYCLES, default 4 (legal minimum 3): number of cycles each test vector is held before its result is sampled.
REQ-002 SHALL have port clk, input, 1: the single clock; all state SHALL change on its rising edge.
REQ-003 SHALL have port reset, input, 1: asynchronous, active-high reset.
REQ-004 SHALL have port start, input, 1: request to run one full test; sampled only in IDLE.
REQ-005 SHALL have port gate_a, output, 4: first input of gates 0..3 (pins 1, 4, 9, 12).
REQ-006 SHALL have port gate_b, output, 4: second input of gates 0..3 (pins 2, 5, 10, 13).
REQ-007 SHALL have port gate_y, input, 4: outputs of gates 0..3 (pins 3, 6, 8, 11); asynchronous to clk.
REQ-008 SHALL have port busy, output, 1: high while a test is in progress.
REQ-009 SHALL have port done, output, 1: one-cycle pulse at the end of a test.
REQ-010 SHALL have port pass, output, 4: per-gate result; bit g is 1 if gate g matched on all vectors.
REQ-011 SHALL have port fail_valid, output, 1: high if any mismatch occurred in the last test.
REQ-012 SHALL have ports fail_gate (output, 2) and fail_vec (output, 2): gate index and vector of the first mismatch.

Function
REQ-013 SHALL implement states IDLE, SETTLE, SAMPLE, DONE.
REQ-014 IDLE with start=1 SHALL go to SETTLE and, on the same edge, set gate=0, vec=0, pass=4'b1111, and clear fail_valid, fail_gate and fail_vec.
REQ-015 Vector order SHALL be 00, 01, 10, 11, with gate_a[g]=vec[1] and gate_b[g]=vec[0] for the gate under test; all other gate inputs SHALL be driven 0.
REQ-016 gate_y SHALL pass through a 2-flop synchronizer before comparison.
REQ-017 SETTLE SHALL last exactly SETTLE_CYCLES cycles (down-counter loaded with SETTLE_CYCLES-1 on entry) and then go to SAMPLE.
REQ-018 SAMPLE SHALL last 1 cycle and compare synchronized gate_y[gate] with vec[1]|vec[0].
REQ-019 On a SAMPLE mismatch, pass[gate] SHALL clear; if fail_valid=0, fail_valid SHALL set and fail_gate/fail_vec SHALL capture the current gate/vec; later mismatches SHALL NOT overwrite them.
REQ-020 After SAMPLE, vec SHALL increment; when vec wraps 11->00, gate SHALL increment; after gate=3, vec=11 the FSM SHALL go to DONE, otherwise back to SETTLE.
REQ-021 DONE SHALL assert done for exactly 1 cycle and then return to IDLE; start SHALL NOT be honoured in DONE.
REQ-022 busy SHALL be 1 in SETTLE, SAMPLE and DONE, and 0 in IDLE.
REQ-023 With a start edge at cycle k, done SHALL be high in cycle k+1+16*(SETTLE_CYCLES+1) (k+81 at default).
REQ-024 start while busy SHALL be ignored; start held high SHALL begin a new run on the first IDLE cycle.
REQ-025 pass, fail_valid, fail_gate and fail_vec SHALL hold until the next start or reset.

Reset
REQ-026 reset SHALL immediately force IDLE, gate_a=gate_b=0, busy=0, done=0, pass=0, fail_valid=0, fail_gate=0, fail_vec=0, counters=0, synchronizer=0.
REQ-027 reset mid-test SHALL abort the test without asserting done; the next start SHALL run a complete test.

Structure
REQ-028 Shared package or_tester_pkg SHALL hold the state enum, NUM_GATES=4 and NUM_VECS=4.
REQ-029 The settle down-counter SHALL be one sub-module, settle_timer (load, count, zero flag).
REQ-030 The gate under test SHALL NOT be instantiated inside the tester; the board top SHALL connect it.

Verification
REQ-031 Correct quad-OR model, start pulse at cycle 0 -> done in cycle 81; pass=1111; fail_valid=0.
REQ-032 Gate 2 output stuck at 0 -> pass=1011; fail_gate=2; fail_vec=01.
REQ-033 Gate 0 replaced by AND, gate 3 stuck at 1 -> pass=0110; fail_gate=0; fail_vec=01 (first failure retained).
REQ-034 reset asserted in cycle 30 of a run -> busy, done, gate_a, gate_b and pass at 0 with no clock edge; a new start then completes with pass=1111.
REQ-035 start pulsed again in cycle 40 of a run -> ignored; single done in cycle 81.
REQ-036 start held high -> back-to-back runs, done pulses 82 cycles apart, busy low 1 cycle between runs.

Source files
------------

// File: rtl/or_tester_pkg.sv
// Shared types and constants for the quad two-input OR gate tester.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package or_tester_pkg;

  localparam int NUM_GATES = 4;
  localparam int NUM_VECS  = 4;
  localparam int GATE_W    = $clog2(NUM_GATES);
  localparam int VEC_W     = $clog2(NUM_VECS);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETTLE = 2'd1,
    SAMPLE = 2'd2,
    DONE   = 2'd3
  } state_t;

  // Reference OR response for a two-bit vector {a, b}.
  function automatic logic or_expect(input logic [VEC_W-1:0] v);
    return v[1] | v[0];
  endfunction

endpackage

// File: rtl/settle_timer.sv
// Loadable down-counter that times how long a test vector is held on the pins.
// Latency: load takes effect on the next edge; zero is combinational from the count.
// Backpressure: none; count is a plain enable and the counter parks at zero.
module settle_timer #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             count,
  output logic             zero
);

  logic [WIDTH-1:0] cnt;

  // Load wins over count; counting stops at zero so the flag stays stable.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val;
    end else if (count && (cnt != '0)) begin
      cnt <= cnt - 1'b1;
    end
  end

  assign zero = (cnt == '0);

endmodule

// File: rtl/or_gate_tester.sv
// Exercises an external quad 2-input OR gate with all four vectors per gate and reports per-gate pass/fail.
// Latency: one run takes 1+16*(SETTLE_CYCLES+1) cycles from the start edge to the done pulse.
// Backpressure: none; start is sampled only in IDLE and ignored while busy.
module or_gate_tester
  import or_tester_pkg::*;
#(
  parameter int SETTLE_CYCLES = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  output logic [NUM_GATES-1:0] gate_a,
  output logic [NUM_GATES-1:0] gate_b,
  input  logic [NUM_GATES-1:0] gate_y,
  output logic                 busy,
  output logic                 done,
  output logic [NUM_GATES-1:0] pass,
  output logic                 fail_valid,
  output logic [GATE_W-1:0]    fail_gate,
  output logic [VEC_W-1:0]     fail_vec
);

  localparam int TIMER_W = $clog2(SETTLE_CYCLES) + 1;
  localparam logic [TIMER_W-1:0] SETTLE_LOAD = TIMER_W'(SETTLE_CYCLES - 1);
  localparam logic [GATE_W-1:0]  LAST_GATE   = GATE_W'(NUM_GATES - 1);
  localparam logic [VEC_W-1:0]   LAST_VEC    = VEC_W'(NUM_VECS - 1);

  state_t state;
  state_t state_n;

  logic [GATE_W-1:0]    gate;
  logic [VEC_W-1:0]     vec;
  logic [NUM_GATES-1:0] y_meta;
  logic [NUM_GATES-1:0] y_sync;

  logic tmr_load;
  logic tmr_count;
  logic tmr_zero;

  logic start_run;
  logic last_vector;
  logic mismatch;

  assign start_run   = (state == IDLE) && start;
  assign last_vector = (gate == LAST_GATE) && (vec == LAST_VEC);
  assign mismatch    = (y_sync[gate] != or_expect(vec));

  settle_timer #(
    .WIDTH (TIMER_W)
  ) u_settle_timer (
    .clk      (clk),
    .reset    (reset),
    .load     (tmr_load),
    .load_val (SETTLE_LOAD),
    .count    (tmr_count),
    .zero     (tmr_zero)
  );

  // Two-flop synchronizer: the gate outputs have no timing relationship to clk.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      y_meta <= '0;
      y_sync <= '0;
    end else begin
      y_meta <= gate_y;
      y_sync <= y_meta;
    end
  end

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_n;
    end
  end

  // Next-state and timer control; the timer is reloaded on every entry to SETTLE.
  always_comb begin
    state_n   = state;
    tmr_load  = 1'b0;
    tmr_count = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          state_n  = SETTLE;
          tmr_load = 1'b1;
        end
      end
      SETTLE: begin
        if (tmr_zero) begin
          state_n = SAMPLE;
        end else begin
          tmr_count = 1'b1;
        end
      end
      SAMPLE: begin
        if (last_vector) begin
          state_n = DONE;
        end else begin
          state_n  = SETTLE;
          tmr_load = 1'b1;
        end
      end
      DONE: begin
        state_n = IDLE;
      end
      default: begin
        state_n = IDLE;
      end
    endcase
  end

  // Vector sequencing: vec steps 00..11 per gate, gate advances when vec wraps.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      gate <= '0;
      vec  <= '0;
    end else if (start_run) begin
      gate <= '0;
      vec  <= '0;
    end else if (state == SAMPLE) begin
      vec <= vec + 1'b1;
      if (vec == LAST_VEC) begin
        gate <= gate + 1'b1;
      end
    end
  end

  // Result capture: a mismatch clears the gate's pass bit; only the first mismatch is logged.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pass       <= '0;
      fail_valid <= 1'b0;
      fail_gate  <= '0;
      fail_vec   <= '0;
    end else if (start_run) begin
      pass       <= '1;
      fail_valid <= 1'b0;
      fail_gate  <= '0;
      fail_vec   <= '0;
    end else if ((state == SAMPLE) && mismatch) begin
      pass[gate] <= 1'b0;
      if (!fail_valid) begin
        fail_valid <= 1'b1;
        fail_gate  <= gate;
        fail_vec   <= vec;
      end
    end
  end

  // Drive only the gate under test, and only while a vector is being applied.
  always_comb begin
    gate_a = '0;
    gate_b = '0;
    if ((state == SETTLE) || (state == SAMPLE)) begin
      gate_a[gate] = vec[1];
      gate_b[gate] = vec[0];
    end
  end

  assign busy = (state != IDLE);
  assign done = (state == DONE);

endmodule

// File: tb/tb_or_gate_tester.sv
module tb_or_gate_tester;

  localparam int S       = 4;
  localparam int RUN_LEN = 1 + 16 * (S + 1);

  // Gate behaviour codes for the board model.
  localparam logic [1:0] M_OR  = 2'd0;
  localparam logic [1:0] M_AND = 2'd1;
  localparam logic [1:0] M_ST0 = 2'd2;
  localparam logic [1:0] M_ST1 = 2'd3;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       start = 1'b0;
  logic [3:0] gate_a;
  logic [3:0] gate_b;
  logic [3:0] gate_y;
  logic       busy;
  logic       done;
  logic [3:0] pass;
  logic       fail_valid;
  logic [1:0] fail_gate;
  logic [1:0] fail_vec;

  logic [7:0] modes = 8'h00;

  int cyc = 0;
  int errors = 0;
  int checks = 0;

  typedef struct {
    int         done_cyc;
    logic [3:0] pass;
    logic       fv;
    logic [1:0] fg;
    logic [1:0] fvec;
  } exp_t;

  exp_t sb[$];

  or_gate_tester #(
    .SETTLE_CYCLES (S)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .gate_a     (gate_a),
    .gate_b     (gate_b),
    .gate_y     (gate_y),
    .busy       (busy),
    .done       (done),
    .pass       (pass),
    .fail_valid (fail_valid),
    .fail_gate  (fail_gate),
    .fail_vec   (fail_vec)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Board model: each of the four gates behaves according to its mode code.
  always_comb begin
    gate_y = 4'b0000;
    for (int g = 0; g < 4; g++) begin
      case (modes[2*g +: 2])
        M_OR:    gate_y[g] = gate_a[g] | gate_b[g];
        M_AND:   gate_y[g] = gate_a[g] & gate_b[g];
        M_ST0:   gate_y[g] = 1'b0;
        default: gate_y[g] = 1'b1;
      endcase
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, errors=%0d", errors);
    $fatal(1, "watchdog");
  end

  task automatic wait_cycle(input int target);
    while (cyc < target) @(negedge clk);
  endtask

  // Pulse start for one cycle; returns the cycle in which start was high.
  task automatic pulse_start(output int c);
    @(negedge clk);
    start = 1'b1;
    c = cyc;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_done(input int limit, output int at, output bit ok);
    ok = 1'b0;
    at = -1;
    for (int i = 0; i < limit; i++) begin
      @(negedge clk);
      if (done) begin
        at = cyc;
        ok = 1'b1;
        return;
      end
    end
  endtask

  task automatic test_reset;
    reset = 1'b1;
    repeat (3) @(negedge clk);
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", busy); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b want 0", done); end
    checks++; if (pass !== 4'b0000) begin errors++; $display("FAIL reset_pass: got %b want 0000", pass); end
    checks++; if (fail_valid !== 1'b0) begin errors++; $display("FAIL reset_fail_valid: got %b want 0", fail_valid); end
    checks++; if ({fail_gate, fail_vec} !== 4'b0000) begin errors++; $display("FAIL reset_fail_idx: got %b/%b want 00/00", fail_gate, fail_vec); end
    checks++; if ({gate_a, gate_b} !== 8'h00) begin errors++; $display("FAIL reset_pins: got a=%b b=%b want 0000/0000", gate_a, gate_b); end
    reset = 1'b0;
    @(negedge clk);
  endtask

  // Several board fault patterns; expected results are written out by hand.
  task automatic test_patterns;
    logic [7:0] pat_modes [5] = '{8'h00, 8'h20, 8'hC1, 8'h0C, 8'h40};
    logic [3:0] pat_pass  [5] = '{4'b1111, 4'b1011, 4'b0110, 4'b1101, 4'b0111};
    logic       pat_fv    [5] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
    logic [1:0] pat_fg    [5] = '{2'd0, 2'd2, 2'd0, 2'd1, 2'd3};
    logic [1:0] pat_fvec  [5] = '{2'd0, 2'd1, 2'd1, 2'd0, 2'd1};
    int c, at;
    bit ok;
    exp_t e;
    for (int p = 0; p < 5; p++) begin
      modes = pat_modes[p];
      pulse_start(c);
      sb.push_back('{c + RUN_LEN, pat_pass[p], pat_fv[p], pat_fg[p], pat_fvec[p]});
      wait_cycle(c + 1);
      checks++; if (busy !== 1'b1) begin errors++; $display("FAIL pat%0d_busy: got %b want 1", p, busy); end
      wait_cycle(c + 6);
      checks++; if ({gate_a, gate_b} !== {4'b0000, 4'b0001}) begin errors++; $display("FAIL pat%0d_vec_g0v1: got a=%b b=%b want 0000/0001", p, gate_a, gate_b); end
      wait_cycle(c + 31);
      checks++; if ({gate_a, gate_b} !== {4'b0010, 4'b0000}) begin errors++; $display("FAIL pat%0d_vec_g1v2: got a=%b b=%b want 0010/0000", p, gate_a, gate_b); end
      wait_cycle(c + 76);
      checks++; if ({gate_a, gate_b} !== {4'b1000, 4'b1000}) begin errors++; $display("FAIL pat%0d_vec_g3v3: got a=%b b=%b want 1000/1000", p, gate_a, gate_b); end
      wait_done(200, at, ok);
      e = sb.pop_front();
      checks++; if (!ok || at != e.done_cyc) begin errors++; $display("FAIL pat%0d_done_cycle: got %0d want %0d", p, at, e.done_cyc); end
      checks++; if (pass !== e.pass) begin errors++; $display("FAIL pat%0d_pass: got %b want %b", p, pass, e.pass); end
      checks++; if (fail_valid !== e.fv) begin errors++; $display("FAIL pat%0d_fail_valid: got %b want %b", p, fail_valid, e.fv); end
      if (e.fv) begin
        checks++; if ({fail_gate, fail_vec} !== {e.fg, e.fvec}) begin errors++; $display("FAIL pat%0d_first_fail: got g%0d v%b want g%0d v%b", p, fail_gate, fail_vec, e.fg, e.fvec); end
      end
      @(negedge clk);
      checks++; if (done !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL pat%0d_after_done: got done=%b busy=%b want 0/0", p, done, busy); end
      checks++; if (pass !== e.pass) begin errors++; $display("FAIL pat%0d_pass_hold: got %b want %b", p, pass, e.pass); end
    end
    modes = 8'h00;
  endtask

  task automatic test_reset_midrun;
    int c, at;
    bit ok;
    exp_t e;
    modes = 8'h00;
    pulse_start(c);
    wait_cycle(c + 30);
    reset = 1'b1;
    #1;
    checks++; if (busy !== 1'b0 || done !== 1'b0) begin errors++; $display("FAIL midreset_ctrl: got busy=%b done=%b want 0/0", busy, done); end
    checks++; if ({gate_a, gate_b} !== 8'h00) begin errors++; $display("FAIL midreset_pins: got a=%b b=%b want 0000/0000", gate_a, gate_b); end
    checks++; if (pass !== 4'b0000) begin errors++; $display("FAIL midreset_pass: got %b want 0000", pass); end
    repeat (2) @(negedge clk);
    reset = 1'b0;
    // The aborted run must never signal done.
    wait_done(90, at, ok);
    checks++; if (ok) begin errors++; $display("FAIL midreset_no_done: got done at %0d want none", at); end
    pulse_start(c);
    sb.push_back('{c + RUN_LEN, 4'b1111, 1'b0, 2'd0, 2'd0});
    wait_done(200, at, ok);
    e = sb.pop_front();
    checks++; if (!ok || at != e.done_cyc) begin errors++; $display("FAIL midreset_rerun_done: got %0d want %0d", at, e.done_cyc); end
    checks++; if (pass !== e.pass || fail_valid !== e.fv) begin errors++; $display("FAIL midreset_rerun_result: got %b/%b want %b/%b", pass, fail_valid, e.pass, e.fv); end
  endtask

  task automatic test_restart_ignored;
    int c, c2, at, extra;
    bit ok;
    exp_t e;
    pulse_start(c);
    sb.push_back('{c + RUN_LEN, 4'b1111, 1'b0, 2'd0, 2'd0});
    wait_cycle(c + 39);
    pulse_start(c2);
    wait_done(200, at, ok);
    e = sb.pop_front();
    checks++; if (!ok || at != e.done_cyc) begin errors++; $display("FAIL restart_done_cycle: got %0d want %0d (second start at %0d)", at, e.done_cyc, c2); end
    checks++; if (pass !== e.pass) begin errors++; $display("FAIL restart_pass: got %b want %b", pass, e.pass); end
    extra = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (done) extra++;
    end
    checks++; if (extra != 0 || busy !== 1'b0) begin errors++; $display("FAIL restart_extra: got %0d extra done, busy=%b want 0/0", extra, busy); end
  endtask

  task automatic test_back_to_back;
    int c, at;
    bit ok;
    exp_t e;
    @(negedge clk);
    start = 1'b1;
    c = cyc;
    sb.push_back('{c + RUN_LEN, 4'b1111, 1'b0, 2'd0, 2'd0});
    sb.push_back('{c + 2 * RUN_LEN + 1, 4'b1111, 1'b0, 2'd0, 2'd0});
    wait_done(200, at, ok);
    e = sb.pop_front();
    checks++; if (!ok || at != e.done_cyc) begin errors++; $display("FAIL b2b_done1: got %0d want %0d", at, e.done_cyc); end
    @(negedge clk);
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL b2b_idle_gap: got busy=%b want 0", busy); end
    @(negedge clk);
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL b2b_restart: got busy=%b want 1", busy); end
    wait_done(200, at, ok);
    start = 1'b0;
    e = sb.pop_front();
    checks++; if (!ok || at != e.done_cyc) begin errors++; $display("FAIL b2b_done2: got %0d want %0d", at, e.done_cyc); end
    repeat (3) @(negedge clk);
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL b2b_stop: got busy=%b want 0", busy); end
  endtask

  initial begin
    test_reset();
    test_patterns();
    test_reset_midrun();
    test_restart_ignored();
    test_back_to_back();
    checks++; if (sb.size() != 0) begin errors++; $display("FAIL scoreboard_drain: got %0d left want 0", sb.size()); end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
